// File: rtl/wb_slot_decoder_if.sv
// wb_slot_decoder_if: CPU-side request/response and per-slot strobe/data/ack signals of the slot decoder.
interface wb_slot_decoder_if #(
  parameter int NSLOTS = 16,
  parameter int DW = 32
);
  localparam int CW = $clog2(NSLOTS);
  logic [CW-1:0] chipselect;
  logic cyc_i;
  logic we_i;
  logic [DW-1:0] dat_o;
  logic ack_o;
  logic err_o;
  logic [NSLOTS-1:0] slave_stb_o;
  logic [NSLOTS-1:0] slave_rd_o;
  logic [NSLOTS*DW-1:0] slave_dat_i;
  logic [NSLOTS-1:0] slave_ack_i;
  modport master (
    output chipselect, cyc_i, we_i, slave_dat_i, slave_ack_i,
    input dat_o, ack_o, err_o, slave_stb_o, slave_rd_o
  );
  modport slave (
    input chipselect, cyc_i, we_i, slave_dat_i, slave_ack_i,
    output dat_o, ack_o, err_o, slave_stb_o, slave_rd_o
  );
endinterface

// File: rtl/wb_slot_decoder.sv
// wb_slot_decoder: slot decoder driving one-hot strobes, read mux and merged ack/err for the CPU bus.
// Define BUS_TIMEOUT_EN to raise err_o when an external slot stays unacked for TIMEOUT busy cycles.
module wb_slot_decoder #(
  parameter int NSLOTS = 16,
  parameter int DW = 32,
  parameter logic [NSLOTS-1:0] SLOT_MASK = 'h00B6,
  parameter logic [NSLOTS-1:0] LOCAL_MASK = 'h0006,
  parameter int LOCAL_WAIT = 2,
  parameter int TIMEOUT = 1023
) (
  input logic sysclock,
  input logic rst_i,
  wb_slot_decoder_if.slave bus
);
  localparam int CW = $clog2(NSLOTS);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CW-1:0] slot_q;
  logic we_q;
  logic [9:0] cnt;
  logic mapped, local_slot, ext_ack, live, ack, err;
  logic [DW-1:0] rd_mux;
  logic [NSLOTS-1:0] stb;
  always_comb begin
    mapped = 1'b0;
    local_slot = 1'b0;
    ext_ack = 1'b0;
    rd_mux = '0;
    for (int n = 0; n < NSLOTS; n++)
      if (slot_q == CW'(n)) begin
        mapped = SLOT_MASK[n];
        local_slot = SLOT_MASK[n] & LOCAL_MASK[n];
        ext_ack = bus.slave_ack_i[n];
        rd_mux = bus.slave_dat_i[n*DW +: DW];
      end
  end
  // cyc_i gates everything in BUSY so an abort drops strobe and suppresses ack/err at once
  assign live = state == BUSY && bus.cyc_i;
  assign ack = live && mapped && (local_slot ? cnt == 10'(LOCAL_WAIT) : ext_ack);
`ifdef BUS_TIMEOUT_EN
  assign err = live && (!mapped || (!local_slot && !ext_ack && cnt == 10'(TIMEOUT)));
`else
  assign err = live && !mapped;
`endif
  assign stb = (live && mapped) ? NSLOTS'(1) << slot_q : '0;
  assign bus.slave_stb_o = stb;
  assign bus.slave_rd_o = we_q ? '0 : stb;
  assign bus.ack_o = ack;
  assign bus.err_o = err;
  assign bus.dat_o = (state == BUSY && !we_q) ? rd_mux : '0;
  // DONE is the dead cycle; like IDLE it captures a pending cyc_i on its exit edge
  always_ff @(posedge sysclock or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      slot_q <= '0;
      we_q <= 1'b0;
      cnt <= '0;
    end else if (state == BUSY) begin
      cnt <= (cnt == 10'(TIMEOUT)) ? cnt : cnt + 10'd1;
      state <= !bus.cyc_i ? IDLE : (ack || err) ? DONE : BUSY;
    end else begin
      state <= bus.cyc_i ? BUSY : IDLE;
      if (bus.cyc_i) begin
        slot_q <= bus.chipselect;
        we_q <= bus.we_i;
        cnt <= '0;
      end
    end
endmodule
